// File: rtl/axis_adc_decimator.sv
// axis_adc_decimator
//   Block-averaging decimator for a signed ADC sample stream. Sums 2^dec_log2
//   consecutive samples, emits (sum >>> dec_log2) on an AXI-Stream master and
//   raises m_axis_tlast on every PACKET_LEN-th result.
// Ports
//   aclk, areset          clock, asynchronous active-high reset
//   s_axis_t{data,valid}  input samples (two's complement), s_axis_tready out
//   dec_log2              decimation exponent, clamped to MAX_DEC_LOG2
//   clear                 synchronous flush of partial block and packet count
//   m_axis_t{data,valid,last}, m_axis_tready   averaged results
module axis_adc_decimator #(
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_DEC_LOG2 = 10,
    parameter int PACKET_LEN   = 256
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic [DATA_WIDTH-1:0]             s_axis_tdata,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic [$clog2(MAX_DEC_LOG2+1)-1:0] dec_log2,
    input  logic                              clear,
    output logic [DATA_WIDTH-1:0]             m_axis_tdata,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast
);

    localparam int ACC_W = DATA_WIDTH + MAX_DEC_LOG2;
    localparam int SHW   = $clog2(MAX_DEC_LOG2 + 1);
    localparam int CNT_W = (MAX_DEC_LOG2 > 0) ? MAX_DEC_LOG2 : 1;
    localparam int PKT_W = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;
    localparam logic [PKT_W-1:0] PKT_LAST = PKT_W'(PACKET_LEN - 1);

    typedef enum logic {ACC, HOLD} state_t;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [SHW-1:0]           shift_q, shift_d;
    logic [PKT_W-1:0]         pkt_q, pkt_d;
    logic [DATA_WIDTH-1:0]    tdata_q, tdata_d;
    logic                     tlast_q, tlast_d;

    logic                     s_hs, m_hs, blk_last;
    logic [SHW-1:0]           dec_eff, shift_cur;
    logic [CNT_W-1:0]         blk_max;
    logic [PKT_W-1:0]         pkt_adv;
    logic signed [ACC_W-1:0]  samp_ext, acc_sum;

    assign m_axis_tvalid = (state_q == HOLD);
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
    // While holding a result, a new sample may only enter together with the
    // result leaving, so the sink's ready passes straight through.
    assign s_axis_tready = (state_q == ACC) || m_axis_tready;

    assign s_hs = s_axis_tvalid && s_axis_tready;
    assign m_hs = (state_q == HOLD) && m_axis_tready;

    assign dec_eff   = (dec_log2 > SHW'(MAX_DEC_LOG2)) ? SHW'(MAX_DEC_LOG2) : dec_log2;
    // The exponent is captured with the first sample of a block; later samples
    // keep using the captured value.
    assign shift_cur = (cnt_q == '0) ? dec_eff : shift_q;
    assign blk_max   = ~({CNT_W{1'b1}} << shift_cur);
    assign blk_last  = (cnt_q == blk_max);

    assign samp_ext = ACC_W'(signed'(s_axis_tdata));
    assign acc_sum  = acc_q + samp_ext;

    assign pkt_adv = !m_hs ? pkt_q : ((pkt_q == PKT_LAST) ? '0 : pkt_q + PKT_W'(1));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        pkt_d   = pkt_q;
        tdata_d = tdata_q;
        tlast_d = tlast_q;

        if (m_hs) begin
            state_d = ACC;
        end

        if (clear) begin
            // Any sample offered this cycle is dropped; a held result survives
            // but can no longer close a packet.
            acc_d   = '0;
            cnt_d   = '0;
            pkt_d   = '0;
            tlast_d = 1'b0;
        end else begin
            pkt_d = pkt_adv;
            if (s_hs) begin
                shift_d = shift_cur;
                if (blk_last) begin
                    tdata_d = DATA_WIDTH'(acc_sum >>> shift_cur);
                    // Index of the new result is the count after any
                    // simultaneous hand-off of the previous one.
                    tlast_d = (pkt_adv == PKT_LAST);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            pkt_q   <= '0;
            tdata_q <= '0;
            tlast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            pkt_q   <= pkt_d;
            tdata_q <= tdata_d;
            tlast_q <= tlast_d;
        end
    end

endmodule
